// File: rtl/spi_master_seq.sv
// ---------------------------------------------------------------------------
// spi_master_seq
//
// Single-word SPI master, mode 0 (sck idles low, data sampled on sck rise).
// One transfer moves WIDTH bits MSB first on mosi and collects WIDTH bits
// from miso. Each sck half-period lasts CLK_DIV clk cycles.
//
// Sequence per transfer:
//   IDLE -> LEAD -> (HIGH -> LOW) x (WIDTH-1) -> HIGH -> END -> IDLE
// Every phase lasts CLK_DIV cycles, so cs_n is low for
// CLK_DIV*(2*WIDTH+1) cycles and sck shows exactly WIDTH rising edges.
//
// Ports:
//   clk_i       system clock, rising edge
//   rst_i       synchronous active-high reset, aborts any transfer
//   tx_data_i   word to send, captured on acceptance
//   tx_valid_i  request; accepted when tx_ready_o is high on a clk edge
//   tx_ready_o  high exactly while idle (low for one cycle after reset)
//   rx_data_o   last received word, held until the next rx_valid_o pulse
//   rx_valid_o  one-cycle pulse when rx_data_o updates
//   sck_o       SPI clock
//   mosi_o      serial data out
//   miso_i      serial data in
//   cs_n_o      active-low chip select
//
// All outputs come straight from flops.
// ---------------------------------------------------------------------------
module spi_master_seq #(
    parameter int WIDTH   = 8,
    parameter int CLK_DIV = 2
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [WIDTH-1:0] tx_data_i,
    input  logic             tx_valid_i,
    output logic             tx_ready_o,
    output logic [WIDTH-1:0] rx_data_o,
    output logic             rx_valid_o,
    output logic             sck_o,
    output logic             mosi_o,
    input  logic             miso_i,
    output logic             cs_n_o
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int BW = $clog2(WIDTH + 1);

    localparam logic [CW-1:0] CNT_LOAD = CW'(CLK_DIV - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEAD,
        S_HIGH,
        S_LOW,
        S_END
    } state_e;

    state_e           state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [BW-1:0]    bit_q, bit_d;
    logic [WIDTH-1:0] tx_sh_q, tx_sh_d;
    logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [WIDTH-1:0] rx_data_q, rx_data_d;
    logic             tx_ready_q, tx_ready_d;
    logic             rx_valid_q, rx_valid_d;
    logic             sck_q, sck_d;
    logic             cs_n_q, cs_n_d;

    logic             accept;
    logic             phase_done;
    logic             state_chg;
    logic             enter_high;
    logic             enter_low;

    // tx_ready_q tracks the idle state, so no separate state check is needed.
    assign accept     = tx_valid_i && tx_ready_q;
    assign phase_done = (cnt_q == '0);
    assign state_chg  = (state_d != state_q);
    assign enter_high = state_chg && (state_d == S_HIGH);
    assign enter_low  = state_chg && (state_d == S_LOW);

    // -----------------------------------------------------------------------
    // State register (also holds all datapath and output flops)
    // -----------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            cnt_q      <= CNT_LOAD;
            bit_q      <= '0;
            tx_sh_q    <= '0;
            rx_sh_q    <= '0;
            rx_data_q  <= '0;
            tx_ready_q <= 1'b0;
            rx_valid_q <= 1'b0;
            sck_q      <= 1'b0;
            cs_n_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_q      <= bit_d;
            tx_sh_q    <= tx_sh_d;
            rx_sh_q    <= rx_sh_d;
            rx_data_q  <= rx_data_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            sck_q      <= sck_d;
            cs_n_q     <= cs_n_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept)     state_d = S_LEAD;
            S_LEAD: if (phase_done) state_d = S_HIGH;
            // bit_q already counts the HIGH phase in progress
            S_HIGH: if (phase_done) state_d = (bit_q == BIT_LAST) ? S_END : S_LOW;
            S_LOW:  if (phase_done) state_d = S_HIGH;
            S_END:  if (phase_done) state_d = S_IDLE;
            default:                state_d = S_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Output / datapath next values
    // -----------------------------------------------------------------------
    always_comb begin
        // Half-period counter reloads on every phase change so a phase never
        // inherits leftover count from the previous one.
        if (state_chg || (state_q == S_IDLE)) begin
            cnt_d = CNT_LOAD;
        end else begin
            cnt_d = cnt_q - 1'b1;
        end

        tx_ready_d = (state_d == S_IDLE);
        cs_n_d     = (state_d == S_IDLE);
        sck_d      = (state_d == S_HIGH);
        rx_valid_d = (state_q == S_END) && (state_d == S_IDLE);
        rx_data_d  = rx_valid_d ? rx_sh_q : rx_data_q;

        bit_d   = bit_q;
        tx_sh_d = tx_sh_q;
        rx_sh_d = rx_sh_q;

        if (accept) begin
            tx_sh_d = tx_data_i;
            bit_d   = '0;
        end

        // Sample miso as sck rises; first bit ends up in the MSB.
        if (enter_high) begin
            rx_sh_d = {rx_sh_q[WIDTH-2:0], miso_i};
            bit_d   = bit_q + 1'b1;
        end

        // mosi is the shifter MSB: advance only on sck fall. After the last
        // HIGH the block enters END instead of LOW, so the LSB stays put.
        if (enter_low) begin
            tx_sh_d = {tx_sh_q[WIDTH-2:0], 1'b0};
        end

        // Return mosi to 0 once the transfer is over.
        if (rx_valid_d) begin
            tx_sh_d = '0;
        end
    end

    assign tx_ready_o = tx_ready_q;
    assign rx_data_o  = rx_data_q;
    assign rx_valid_o = rx_valid_q;
    assign sck_o      = sck_q;
    assign mosi_o     = tx_sh_q[WIDTH-1];
    assign cs_n_o     = cs_n_q;

endmodule

// File: tb/tb_spi_master_seq.sv
module tb_spi_master_seq;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    // instance 0: WIDTH=8, CLK_DIV=2
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       sck, mosi, miso, cs_n;
    logic       loop_en, miso_fix;
    // instance 1: WIDTH=8, CLK_DIV=1, always looped back
    logic [7:0] tx_data1;
    logic       tx_valid1;
    logic       tx_ready1;
    logic [7:0] rx_data1;
    logic       rx_valid1;
    logic       sck1, mosi1, cs_n1;

    assign miso = loop_en ? mosi : miso_fix;

    spi_master_seq #(.WIDTH(8), .CLK_DIV(2)) u_dut (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
        .tx_ready_o(tx_ready), .rx_data_o(rx_data), .rx_valid_o(rx_valid),
        .sck_o(sck), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n)
    );

    spi_master_seq #(.WIDTH(8), .CLK_DIV(1)) u_dut1 (
        .clk_i(clk), .rst_i(rst), .tx_data_i(tx_data1), .tx_valid_i(tx_valid1),
        .tx_ready_o(tx_ready1), .rx_data_o(rx_data1), .rx_valid_o(rx_valid1),
        .sck_o(sck1), .mosi_o(mosi1), .miso_i(mosi1), .cs_n_o(cs_n1)
    );

    // ------------------------------------------------------------------
    // Bus monitors (sample at negedge; the stimulus block reads at negedge+1)
    // ------------------------------------------------------------------
    int         cs_run = 0, cs_len = 0, cs_hi_run = 0, cs_gap = 0;
    int         sck_rises = 0, rxv_cycles = 0, rxv_pulses = 0;
    logic [7:0] mosi_seq = '0;
    logic [7:0] rx_hist [0:15];
    logic       prev_sck = 1'b0, prev_cs_n = 1'b1, prev_rxv = 1'b0;

    always @(negedge clk) begin
        if (cs_n === 1'b0) begin
            if (prev_cs_n === 1'b1) begin
                cs_gap = cs_hi_run;
                cs_run = 0;
            end
            cs_run++;
        end else begin
            if (prev_cs_n === 1'b0) begin
                cs_len    = cs_run;
                cs_hi_run = 1;
            end else begin
                cs_hi_run++;
            end
        end
        if (sck === 1'b1 && prev_sck === 1'b0) begin
            sck_rises++;
            mosi_seq = {mosi_seq[6:0], mosi};
        end
        if (rx_valid === 1'b1) begin
            rxv_cycles++;
            if (prev_rxv !== 1'b1) begin
                rx_hist[rxv_pulses % 16] = rx_data;
                rxv_pulses++;
            end
        end
        prev_sck  = sck;
        prev_cs_n = cs_n;
        prev_rxv  = rx_valid;
    end

    int         cs1_run = 0, cs1_len = 0, rx1_pulses = 0;
    logic [7:0] rx1_last = '0;
    logic       prev_cs1 = 1'b1;

    always @(negedge clk) begin
        if (cs_n1 === 1'b0) begin
            if (prev_cs1 === 1'b1) cs1_run = 0;
            cs1_run++;
        end else if (prev_cs1 === 1'b0) begin
            cs1_len = cs1_run;
        end
        if (rx_valid1 === 1'b1) begin
            rx1_last = rx_data1;
            rx1_pulses++;
        end
        prev_cs1 = cs_n1;
    end

    // ------------------------------------------------------------------
    // Checking helpers and scoreboard
    // ------------------------------------------------------------------
    int         n_chk  = 0;
    int         n_fail = 0;
    logic [7:0] exp_q [$];
    logic [7:0] exp1_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic cyc(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
        end
    endtask

    // Wait for tx_ready, present one word, release tx_valid after acceptance.
    task automatic send(input logic [7:0] d, input logic [7:0] expv, input bit push);
        int n = 0;
        while (tx_ready !== 1'b1 && n < 200) begin
            cyc();
            n++;
        end
        chk("ready_wait", (n < 200), 1);
        tx_data  = d;
        tx_valid = 1'b1;
        if (push) exp_q.push_back(expv);
        cyc();
        tx_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target, input int budget);
        int n = 0;
        while (rxv_pulses < target && n < budget) begin
            cyc();
            n++;
        end
        chk("rx_valid_timeout", (rxv_pulses >= target), 1);
    endtask

    task automatic sb_check(input string tag, input int idx);
        logic [7:0] e;
        chk({tag, "_sb_nonempty"}, (exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk(tag, rx_hist[idx % 16], e);
        end
    endtask

    // ------------------------------------------------------------------
    // Directed sequence
    // ------------------------------------------------------------------
    int p0, s0, c0;

    initial begin
        rst       = 1'b1;
        tx_data   = '0;
        tx_valid  = 1'b0;
        tx_data1  = '0;
        tx_valid1 = 1'b0;
        loop_en   = 1'b1;
        miso_fix  = 1'b0;
        cyc(3);

        // reset state while rst is still asserted
        chk("rst_cs_n",     cs_n,     1);
        chk("rst_sck",      sck,      0);
        chk("rst_mosi",     mosi,     0);
        chk("rst_rx_valid", rx_valid, 0);
        chk("rst_rx_data",  rx_data,  0);
        chk("rst_tx_ready", tx_ready, 0);
        rst = 1'b0;
        cyc();
        chk("post_rst_tx_ready", tx_ready, 1);

        // loopback 0xA5
        p0 = rxv_pulses; s0 = sck_rises; c0 = rxv_cycles;
        send(8'hA5, 8'hA5, 1'b1);
        chk("busy_tx_ready", tx_ready, 0);
        wait_pulses(p0 + 1, 100);
        cyc(3);
        sb_check("a5_rx_data", p0);
        chk("a5_cs_len",    cs_len, 34);
        chk("a5_sck_rises", sck_rises - s0, 8);
        chk("a5_rxv_cycles", rxv_cycles - c0, 1);
        chk("a5_mosi_seq",  mosi_seq, 8'hA5);
        chk("a5_idle_mosi", mosi, 0);
        chk("a5_idle_cs_n", cs_n, 1);

        // miso tied high, send 0x01
        loop_en = 1'b0; miso_fix = 1'b1;
        p0 = rxv_pulses; s0 = sck_rises;
        send(8'h01, 8'hFF, 1'b1);
        wait_pulses(p0 + 1, 100);
        cyc(3);
        sb_check("ones_rx_data", p0);
        chk("ones_mosi_seq",  mosi_seq, 8'h01);
        chk("ones_sck_rises", sck_rises - s0, 8);
        loop_en = 1'b1; miso_fix = 1'b0;

        // CLK_DIV=1 instance, loopback 0x3C
        chk("d1_ready", tx_ready1, 1);
        tx_data1 = 8'h3C; tx_valid1 = 1'b1; exp1_q.push_back(8'h3C);
        cyc();
        tx_valid1 = 1'b0; tx_data1 = 8'hC3;
        begin
            int n = 0;
            while (rx1_pulses < 1 && n < 100) begin cyc(); n++; end
        end
        chk("d1_rx_timeout", rx1_pulses, 1);
        cyc(2);
        chk("d1_cs_len", cs1_len, 17);
        chk("d1_rx_data", rx1_last, exp1_q.pop_front());

        // back-to-back with tx_valid held; data changed after each accept
        p0 = rxv_pulses; c0 = rxv_cycles;
        while (tx_ready !== 1'b1) cyc();
        tx_data = 8'h11; tx_valid = 1'b1; exp_q.push_back(8'h11);
        cyc();
        tx_data = 8'h22; exp_q.push_back(8'h22);
        wait_pulses(p0 + 1, 100);
        chk("b2b_ready_in_rxv", tx_ready, 1);
        cyc();
        tx_valid = 1'b0; tx_data = 8'h77;
        wait_pulses(p0 + 2, 100);
        cyc(3);
        sb_check("b2b_first", p0);
        sb_check("b2b_second", p0 + 1);
        chk("b2b_gap_ge1",   (cs_gap >= 1), 1);
        chk("b2b_rxv_cycles", rxv_cycles - c0, 2);
        chk("b2b_sb_empty",  exp_q.size(), 0);

        // tx_valid pulsed while busy is ignored
        p0 = rxv_pulses;
        send(8'h5A, 8'h5A, 1'b1);
        cyc(4);
        chk("busy2_tx_ready", tx_ready, 0);
        tx_data = 8'hFF; tx_valid = 1'b1;
        cyc();
        tx_valid = 1'b0;
        wait_pulses(p0 + 1, 100);
        cyc(60);
        sb_check("busy_rx_data", p0);
        chk("busy_one_pulse", rxv_pulses - p0, 1);
        chk("busy_idle_cs_n", cs_n, 1);

        // reset during cycle 10 of a transfer
        p0 = rxv_pulses;
        send(8'h96, 8'h00, 1'b0);
        cyc(9);
        chk("abort_busy_cs_n", cs_n, 0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        s0 = sck_rises;
        chk("abort_cs_n",     cs_n,     1);
        chk("abort_sck",      sck,      0);
        chk("abort_rx_valid", rx_valid, 0);
        chk("abort_mosi",     mosi,     0);
        cyc();
        chk("abort_tx_ready", tx_ready, 1);
        cyc(50);
        chk("abort_no_pulse", rxv_pulses - p0, 0);
        chk("abort_no_sck",   sck_rises - s0, 0);
        chk("abort_cs_stays", cs_n, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
